// File: rtl/combi_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : combi_sequencer
// Description : Exhaustive sweep sequencer for combinational checks. Drives
//               every vector 0..2^INBITS-1 into a DUT/reference pair, with an
//               optional cooldown gap and a settle time per vector, then
//               compares the two outputs. Captures the first mismatch and
//               keeps a saturating mismatch count.
//               Build option: COMBI_SEQ_CONTINUE_EN
//                 undefined -> halt the sweep at the first mismatch
//                 defined   -> sweep all vectors and count every mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module combi_sequencer #(
    parameter int INBITS   = 4,
    parameter int OUTBITS  = 1,
    parameter int COOLDOWN = 2,
    parameter int SETTLE   = 4,
    parameter int CNTW     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [INBITS-1:0]  comp_in,
    output logic               drive_en,
    input  logic [OUTBITS-1:0] verify,
    input  logic [OUTBITS-1:0] comp_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [INBITS-1:0]  fail_in,
    output logic [OUTBITS-1:0] fail_expect,
    output logic [OUTBITS-1:0] fail_got,
    output logic [CNTW-1:0]    fail_count
);

    // Timer must hold the larger of the two per-vector phase lengths.
    localparam int TMAX = (COOLDOWN > SETTLE) ? COOLDOWN : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0]     COOL_LOAD   = TW'(COOLDOWN);
    localparam logic [TW-1:0]     SETTLE_LOAD = TW'(SETTLE);
    localparam logic [TW-1:0]     TIMER_ONE   = TW'(1);
    localparam logic [INBITS-1:0] VEC_LAST    = '1;
    localparam logic [CNTW-1:0]   CNT_MAX     = '1;

`ifdef COMBI_SEQ_CONTINUE_EN
    localparam bit HALT_ON_FAIL = 1'b0;
`else
    localparam bit HALT_ON_FAIL = 1'b1;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COOL   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t            state;
    logic [INBITS-1:0] vec;
    logic [TW-1:0]     timer;
    logic              mismatch;

    // Only meaningful in CHECK, where comp_in has been stable for SETTLE cycles.
    assign mismatch = (comp_out != verify);

    // Sequencer FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            vec         <= '0;
            timer       <= '0;
            comp_in     <= '0;
            drive_en    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_in     <= '0;
            fail_expect <= '0;
            fail_got    <= '0;
            fail_count  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec         <= '0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        fail_in     <= '0;
                        fail_expect <= '0;
                        fail_got    <= '0;
                        fail_count  <= '0;
                        busy        <= 1'b1;
                        comp_in     <= '0;
                        if (COOLDOWN == 0) begin
                            state    <= ST_SETTLE;
                            timer    <= SETTLE_LOAD;
                            drive_en <= 1'b1;
                        end else begin
                            state    <= ST_COOL;
                            timer    <= COOL_LOAD;
                            drive_en <= 1'b0;
                        end
                    end
                end

                ST_COOL: begin
                    if (timer == TIMER_ONE) begin
                        state    <= ST_SETTLE;
                        timer    <= SETTLE_LOAD;
                        drive_en <= 1'b1;
                        comp_in  <= vec;
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end

                ST_SETTLE: begin
                    if (timer == TIMER_ONE) begin
                        state <= ST_CHECK;
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end

                ST_CHECK: begin
                    if (mismatch) begin
                        if (fail_count == '0) begin
                            fail_in     <= vec;
                            fail_expect <= verify;
                            fail_got    <= comp_out;
                        end
                        if (fail_count != CNT_MAX) begin
                            fail_count <= fail_count + 1'b1;
                        end
                    end
                    if ((vec == VEC_LAST) || (HALT_ON_FAIL && mismatch)) begin
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= !mismatch && (fail_count == '0);
                        drive_en <= 1'b0;
                        comp_in  <= '0;
                    end else begin
                        vec <= vec + 1'b1;
                        if (COOLDOWN == 0) begin
                            state    <= ST_SETTLE;
                            timer    <= SETTLE_LOAD;
                            drive_en <= 1'b1;
                            comp_in  <= vec + 1'b1;
                        end else begin
                            state    <= ST_COOL;
                            timer    <= COOL_LOAD;
                            drive_en <= 1'b0;
                            comp_in  <= '0;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_combi_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_combi_sequencer
// Description : Directed self-checking bench for combi_sequencer. Instance A
//               (INBITS=2, COOLDOWN=2, SETTLE=3) sweeps a 1-bit function that
//               can be switched to disagree at inputs 2 and 3; instance C
//               (INBITS=3, COOLDOWN=0, SETTLE=1) checks the no-gap sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_combi_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n   = 1'b0;
    logic start_a = 1'b0;
    logic start_c = 1'b0;
    logic mode    = 1'b0;   // 1: DUT output stuck at 0 (wrong at inputs 2,3)

    logic [1:0]  comp_in_a;
    logic        drive_en_a, verify_a, comp_out_a, busy_a, done_a, pass_a;
    logic [1:0]  fail_in_a;
    logic        fail_expect_a, fail_got_a;
    logic [15:0] fail_count_a;

    logic [2:0]  comp_in_c;
    logic        drive_en_c, verify_c, comp_out_c, busy_c, done_c, pass_c;
    logic [2:0]  fail_in_c;
    logic        fail_expect_c, fail_got_c;
    logic [7:0]  fail_count_c;

    // Reference is input bit 1; the faulty DUT always outputs 0.
    assign verify_a   = comp_in_a[1];
    assign comp_out_a = mode ? 1'b0 : comp_in_a[1];
    assign verify_c   = ^comp_in_c;
    assign comp_out_c = ^comp_in_c;

    combi_sequencer #(
        .INBITS(2), .OUTBITS(1), .COOLDOWN(2), .SETTLE(3), .CNTW(16)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .comp_in(comp_in_a), .drive_en(drive_en_a),
        .verify(verify_a), .comp_out(comp_out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_in(fail_in_a), .fail_expect(fail_expect_a),
        .fail_got(fail_got_a), .fail_count(fail_count_a)
    );

    combi_sequencer #(
        .INBITS(3), .OUTBITS(1), .COOLDOWN(0), .SETTLE(1), .CNTW(8)
    ) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c),
        .comp_in(comp_in_c), .drive_en(drive_en_c),
        .verify(verify_c), .comp_out(comp_out_c),
        .busy(busy_c), .done(done_c), .pass(pass_c),
        .fail_in(fail_in_c), .fail_expect(fail_expect_c),
        .fail_got(fail_got_c), .fail_count(fail_count_c)
    );

`ifdef COMBI_SEQ_CONTINUE_EN
    localparam int MM_CYC = 24;   // sweep runs to the end
    localparam int MM_CNT = 2;    // inputs 2 and 3 both disagree
`else
    localparam int MM_CYC = 18;   // halts at the CHECK of vector 2
    localparam int MM_CNT = 1;
`endif

    int checks = 0;
    int errors = 0;

    // Pulse start for one edge; returns at the negedge after that edge (n=0).
    task automatic pulse_start_a;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
    endtask

    // Advance negedges until done_a or a budget; cycles = -1 on timeout.
    task automatic wait_done_a(input int from_n, output int cycles);
        int n;
        n = from_n;
        while (!done_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        cycles = done_a ? n : -1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (comp_in_a !== 2'd0) begin errors++; $display("FAIL reset_comp_in got %0d want 0", comp_in_a); end
        checks++; if (drive_en_a !== 1'b0) begin errors++; $display("FAIL reset_drive_en got %b want 0", drive_en_a); end
        checks++; if ({busy_a, done_a, pass_a} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy_a, done_a, pass_a}); end
        checks++; if (fail_count_a !== 16'd0) begin errors++; $display("FAIL reset_fail_count got %0d want 0", fail_count_a); end
        checks++; if ({fail_in_a, fail_expect_a, fail_got_a} !== 4'd0) begin errors++; $display("FAIL reset_fail_regs got %h want 0", {fail_in_a, fail_expect_a, fail_got_a}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Clean DUT: trace every cycle of the 24-cycle sweep.
    task automatic test_clean_sweep;
        logic       exp_de;
        logic [1:0] exp_ci;
        mode = 1'b0;
        pulse_start_a();
        for (int n = 0; n < 24; n++) begin
            exp_de = (n % 6) >= 2;
            exp_ci = exp_de ? 2'(n / 6) : 2'd0;
            checks++; if (drive_en_a !== exp_de) begin errors++; $display("FAIL sweep_drive_en n=%0d got %b want %b", n, drive_en_a, exp_de); end
            checks++; if (comp_in_a !== exp_ci) begin errors++; $display("FAIL sweep_comp_in n=%0d got %0d want %0d", n, comp_in_a, exp_ci); end
            checks++; if ({busy_a, done_a} !== 2'b10) begin errors++; $display("FAIL sweep_busy_done n=%0d got %b want 10", n, {busy_a, done_a}); end
            @(negedge clk);
        end
        checks++; if ({busy_a, done_a, pass_a} !== 3'b011) begin errors++; $display("FAIL clean_end_flags got %b want 011", {busy_a, done_a, pass_a}); end
        checks++; if (fail_count_a !== 16'd0) begin errors++; $display("FAIL clean_fail_count got %0d want 0", fail_count_a); end
        checks++; if ({drive_en_a, comp_in_a} !== 3'd0) begin errors++; $display("FAIL clean_done_drive got %b want 000", {drive_en_a, comp_in_a}); end
    endtask

    task automatic test_mismatch;
        int nd;
        mode = 1'b1;
        pulse_start_a();
        wait_done_a(0, nd);
        checks++; if (nd != MM_CYC) begin errors++; $display("FAIL mm_done_cycle got %0d want %0d", nd, MM_CYC); end
        checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL mm_pass got %b want 0", pass_a); end
        checks++; if (fail_in_a !== 2'd2) begin errors++; $display("FAIL mm_fail_in got %0d want 2", fail_in_a); end
        checks++; if (fail_expect_a !== 1'b1) begin errors++; $display("FAIL mm_fail_expect got %b want 1", fail_expect_a); end
        checks++; if (fail_got_a !== 1'b0) begin errors++; $display("FAIL mm_fail_got got %b want 0", fail_got_a); end
        checks++; if (fail_count_a !== 16'(MM_CNT)) begin errors++; $display("FAIL mm_fail_count got %0d want %0d", fail_count_a, MM_CNT); end
    endtask

    task automatic test_no_cooldown;
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        for (int n = 0; n < 16; n++) begin
            checks++; if (drive_en_c !== 1'b1) begin errors++; $display("FAIL nocool_drive_en n=%0d got %b want 1", n, drive_en_c); end
            checks++; if (comp_in_c !== 3'(n / 2)) begin errors++; $display("FAIL nocool_comp_in n=%0d got %0d want %0d", n, comp_in_c, n / 2); end
            checks++; if (done_c !== 1'b0) begin errors++; $display("FAIL nocool_early_done n=%0d got %b want 0", n, done_c); end
            @(negedge clk);
        end
        checks++; if ({done_c, pass_c, busy_c, drive_en_c} !== 4'b1100) begin errors++; $display("FAIL nocool_end got %b want 1100", {done_c, pass_c, busy_c, drive_en_c}); end
        checks++; if (fail_count_c !== 8'd0) begin errors++; $display("FAIL nocool_fail_count got %0d want 0", fail_count_c); end
    endtask

    task automatic test_reset_mid_sweep;
        int nd;
        mode = 1'b0;
        pulse_start_a();
        repeat (8) @(negedge clk);   // n=8: SETTLE of vector 1
        checks++; if ({drive_en_a, comp_in_a} !== 3'b101) begin errors++; $display("FAIL mid_settle_v1 got %b want 101", {drive_en_a, comp_in_a}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({drive_en_a, comp_in_a, busy_a, done_a, pass_a} !== 6'd0) begin errors++; $display("FAIL mid_reset_outputs got %b want 000000", {drive_en_a, comp_in_a, busy_a, done_a, pass_a}); end
        checks++; if ({fail_count_a, fail_in_a, fail_expect_a, fail_got_a} !== 20'd0) begin errors++; $display("FAIL mid_reset_results got %h want 0", {fail_count_a, fail_in_a, fail_expect_a, fail_got_a}); end
        @(negedge clk); rst_n = 1'b1;
        pulse_start_a();
        checks++; if ({drive_en_a, comp_in_a, busy_a} !== 4'b0001) begin errors++; $display("FAIL mid_restart_first got %b want 0001", {drive_en_a, comp_in_a, busy_a}); end
        wait_done_a(0, nd);
        checks++; if (nd != 24) begin errors++; $display("FAIL mid_restart_cycles got %0d want 24", nd); end
        checks++; if ({pass_a, fail_count_a} !== {1'b1, 16'd0}) begin errors++; $display("FAIL mid_restart_result got %h want 10000", {pass_a, fail_count_a}); end
    endtask

    task automatic test_back_to_back;
        int nd;
        mode = 1'b1;
        pulse_start_a();
        repeat (5) @(negedge clk);
        start_a = 1'b1;                 // busy: must be ignored
        @(negedge clk); start_a = 1'b0; // n=6
        repeat (MM_CYC - 7) @(negedge clk);  // n = MM_CYC-1, last CHECK
        start_a = 1'b1;                 // CHECK->DONE edge: must be ignored
        @(negedge clk); start_a = 1'b0; // n = MM_CYC
        checks++; if ({done_a, busy_a} !== 2'b10) begin errors++; $display("FAIL b2b_done_on_time got %b want 10", {done_a, busy_a}); end
        @(negedge clk);
        checks++; if ({done_a, busy_a} !== 2'b10) begin errors++; $display("FAIL b2b_start_at_exit got %b want 10", {done_a, busy_a}); end
        checks++; if ({pass_a, fail_in_a} !== 3'b010) begin errors++; $display("FAIL b2b_result got %b want 010", {pass_a, fail_in_a}); end
        mode = 1'b0;
        pulse_start_a();                // in DONE: restarts
        checks++; if ({busy_a, done_a, pass_a} !== 3'b100) begin errors++; $display("FAIL b2b_restart_flags got %b want 100", {busy_a, done_a, pass_a}); end
        checks++; if ({fail_count_a, fail_in_a, fail_expect_a, fail_got_a} !== 20'd0) begin errors++; $display("FAIL b2b_restart_clear got %h want 0", {fail_count_a, fail_in_a, fail_expect_a, fail_got_a}); end
        wait_done_a(0, nd);
        checks++; if (nd != 24) begin errors++; $display("FAIL b2b_second_cycles got %0d want 24", nd); end
        checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL b2b_second_pass got %b want 1", pass_a); end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_mismatch();
        test_no_cooldown();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
